// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage around the 64-bit ALU: registers one command onto the
// ALU inputs, waits SETTLE cycles, captures the result and flags, and holds them.
module alu_issue_ctrl #(
  parameter int WIDTH  = 64,
  parameter int SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic [3:0]       i_cmd_sel,
  input  logic             i_cmd_cin,
  input  logic             i_cmd_chain,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_cin,
  output logic [3:0]       o_alu_s,
  input  logic [WIDTH-1:0] i_alu_o,
  input  logic             i_alu_cout,
  input  logic             i_alu_oflow,
  input  logic             i_alu_ntive,
  input  logic             i_alu_zero,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_o,
  output logic [3:0]       o_res_flags,
  output logic             o_carry_q,
  output logic             o_oflow_sticky,
  input  logic             i_clr_sticky,
  output logic             o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  localparam logic [3:0] SETTLE_CNT = SETTLE[3:0];

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic             w_accept;
  logic             w_capture;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_cin;
  logic [3:0]       r_alu_s;
  logic [WIDTH-1:0] r_res_o;
  logic [3:0]       r_res_flags;
  logic             r_carry_q;
  logic             r_oflow_sticky;

  assign w_accept  = (r_state == S_IDLE) && i_cmd_valid;
  assign w_capture = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_cmd_valid) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_HOLD;
      S_HOLD:  if (i_res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ALU operand registers only change on accept so the ALU sees stable inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_cin <= 1'b0;
      r_alu_s   <= 4'd0;
      r_cnt     <= 4'd0;
    end else if (w_accept) begin
      r_alu_a   <= i_cmd_a;
      r_alu_b   <= i_cmd_b;
      r_alu_s   <= i_cmd_sel;
      r_alu_cin <= i_cmd_chain ? r_carry_q : i_cmd_cin;
      r_cnt     <= SETTLE_CNT;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_o     <= '0;
      r_res_flags <= 4'd0;
      r_carry_q   <= 1'b0;
    end else if (w_capture) begin
      r_res_o     <= i_alu_o;
      r_res_flags <= {i_alu_cout, i_alu_oflow, i_alu_ntive, i_alu_zero};
      r_carry_q   <= i_alu_cout;
    end
  end

  // A new overflow takes priority over a clear landing on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_oflow_sticky <= 1'b0;
    else if (w_capture && i_alu_oflow) r_oflow_sticky <= 1'b1;
    else if (i_clr_sticky)             r_oflow_sticky <= 1'b0;
  end

  assign o_cmd_ready    = (r_state == S_IDLE);
  assign o_res_valid    = (r_state == S_HOLD);
  assign o_busy         = (r_state != S_IDLE);
  assign o_alu_a        = r_alu_a;
  assign o_alu_b        = r_alu_b;
  assign o_alu_cin      = r_alu_cin;
  assign o_alu_s        = r_alu_s;
  assign o_res_o        = r_res_o;
  assign o_res_flags    = r_res_flags;
  assign o_carry_q      = r_carry_q;
  assign o_oflow_sticky = r_oflow_sticky;

endmodule
